// File: rtl/id_stage_reg_pkg.sv
// ============================================================================
// Module : id_stage_reg_pkg
// Brief  : Opcode, immediate-select and slot types shared by the IF/ID register and the immediate decoder
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_stage_reg_pkg;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

   localparam logic [3:0] IMM_SEL_NONE  = 4'd0;
   localparam logic [3:0] IMM_SEL_I     = 4'd1;
   localparam logic [3:0] IMM_SEL_S     = 4'd2;
   localparam logic [3:0] IMM_SEL_B     = 4'd3;
   localparam logic [3:0] IMM_SEL_J     = 4'd4;
   localparam logic [3:0] IMM_SEL_U     = 4'd5;
   localparam logic [3:0] IMM_SEL_SHAMT = 4'd6;

   // One buffered slot minus the pc, which is kept separately because its width is a parameter.
   typedef struct packed {
      logic [31:0] inst;
      logic [11:0] imm_i_l_jalr;
      logic [11:0] imm_s;
      logic [11:0] imm_b;
      logic [19:0] imm_jal;
      logic [19:0] imm_u;
      logic [3:0]  imm_sel;
   } slot_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   function automatic logic [3:0] imm_sel_of(input logic [6:0] opcode, input logic [2:0] funct3);
      logic [3:0] sel;
      sel = IMM_SEL_NONE;
      case (opcode)
         OPC_LOAD, OPC_JALR:     sel = IMM_SEL_I;
         OPC_OPIMM, OPC_OPIMM32: sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SEL_SHAMT : IMM_SEL_I;
         OPC_STORE:              sel = IMM_SEL_S;
         OPC_BRANCH:             sel = IMM_SEL_B;
         OPC_JAL:                sel = IMM_SEL_J;
         OPC_LUI, OPC_AUIPC:     sel = IMM_SEL_U;
         default:                sel = IMM_SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_reg_inst_field_slice.sv
// ============================================================================
// Module : inst_field_slice
// Brief  : Combinational slicing of raw immediate fields and imm_sel from one instruction
// Rev    : 1.0
// ============================================================================
`default_nettype none

module inst_field_slice
   import id_stage_reg_pkg::*;
(
   input  logic [31:0] inst,
   output logic [11:0] imm_i_l_jalr,
   output logic [11:0] imm_s,
   output logic [11:0] imm_b,
   output logic [19:0] imm_jal,
   output logic [19:0] imm_u,
   output logic [3:0]  imm_sel
);

   // Branch and jump offsets drop bit 0; the decoder re-inserts it as zero.
   assign imm_i_l_jalr = inst[31:20];
   assign imm_s        = {inst[31:25], inst[11:7]};
   assign imm_b        = {inst[31], inst[7], inst[30:25], inst[11:8]};
   assign imm_jal      = {inst[31], inst[19:12], inst[20], inst[30:21]};
   assign imm_u        = inst[31:12];
   assign imm_sel      = imm_sel_of(inst[6:0], inst[14:12]);

endmodule

`default_nettype wire

// File: rtl/id_stage_reg.sv
// ============================================================================
// Module : id_stage_reg
// Brief  : IF->ID pipeline register with 2-entry skid buffer and pre-sliced immediate fields
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage_reg
   import id_stage_reg_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [ILEN-1:0] in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_inst,
   output logic [11:0]     imm_i_l_jalr,
   output logic [11:0]     imm_s,
   output logic [11:0]     imm_b,
   output logic [19:0]     imm_jal,
   output logic [19:0]     imm_u,
   output logic [3:0]      imm_sel
);

   slot_t            in_slot;
   slot_t            main_d, main_q, skid_d, skid_q;
   logic [XLEN-1:0]  main_pc_d, main_pc_q, skid_pc_d, skid_pc_q;
   state_e           state_d, state_q;
   logic             in_ready_d, in_ready_q;
   logic             out_valid_d, out_valid_q;
   logic             accept, deq;

   assign in_slot.inst = in_inst;

   inst_field_slice u_slice (
      .inst         (in_inst),
      .imm_i_l_jalr (in_slot.imm_i_l_jalr),
      .imm_s        (in_slot.imm_s),
      .imm_b        (in_slot.imm_b),
      .imm_jal      (in_slot.imm_jal),
      .imm_u        (in_slot.imm_u),
      .imm_sel      (in_slot.imm_sel)
   );

   assign accept = in_valid & in_ready_q;
   assign deq    = out_valid_q & out_ready;

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      main_pc_d = main_pc_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      if (flush) begin
         state_d        = ST_EMPTY;
         main_d.imm_sel = IMM_SEL_NONE;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d   = ST_ONE;
                  main_d    = in_slot;
                  main_pc_d = in_pc;
               end
            end
            ST_ONE: begin
               if (accept && out_ready) begin
                  main_d    = in_slot;
                  main_pc_d = in_pc;
               end else if (accept) begin
                  state_d   = ST_TWO;
                  skid_d    = in_slot;
                  skid_pc_d = in_pc;
               end else if (out_ready) begin
                  state_d   = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (deq) begin
                  state_d   = ST_ONE;
                  main_d    = skid_q;
                  main_pc_d = skid_pc_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         main_pc_q   <= '0;
         skid_q      <= '0;
         skid_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_q      <= main_d;
         main_pc_q   <= main_pc_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_pc       = main_pc_q;
   assign out_inst     = main_q.inst;
   assign imm_i_l_jalr = main_q.imm_i_l_jalr;
   assign imm_s        = main_q.imm_s;
   assign imm_b        = main_q.imm_b;
   assign imm_jal      = main_q.imm_jal;
   assign imm_u        = main_q.imm_u;
   assign imm_sel      = main_q.imm_sel;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_reg.sv
// ============================================================================
// Module : tb_id_stage_reg
// Brief  : Scoreboard bench for id_stage_reg
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_pc, out_pc;
   logic [31:0] in_inst, out_inst;
   logic [11:0] imm_i_l_jalr, imm_s, imm_b;
   logic [19:0] imm_jal, imm_u;
   logic [3:0]  imm_sel;

   always #5 clk = ~clk;

   id_stage_reg #(.XLEN(64), .ILEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .imm_i_l_jalr(imm_i_l_jalr), .imm_s(imm_s), .imm_b(imm_b),
      .imm_jal(imm_jal), .imm_u(imm_u), .imm_sel(imm_sel)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [11:0] i, s, b;
      logic [19:0] j, u;
      logic [3:0]  sel;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic exp_t model(input logic [63:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      e.i    = inst[31:20];
      e.s    = {inst[31:25], inst[11:7]};
      e.b    = {inst[31], inst[7], inst[30:25], inst[11:8]};
      e.j    = {inst[31], inst[19:12], inst[20], inst[30:21]};
      e.u    = inst[31:12];
      case (inst[6:0])
         7'h03, 7'h67: e.sel = 4'd1;
         7'h13, 7'h1B: e.sel = (inst[13:12] == 2'b01) ? 4'd6 : 4'd1;
         7'h23:        e.sel = 4'd2;
         7'h63:        e.sel = 4'd3;
         7'h6F:        e.sel = 4'd4;
         7'h37, 7'h17: e.sel = 4'd5;
         default:      e.sel = 4'd0;
      endcase
      return e;
   endfunction

   // Transfers are sampled at the falling edge; they take effect on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected_output got pc=%h inst=%h, expected no output", out_pc, out_inst);
            end else begin
               e = sb.pop_front();
               if ({out_pc, out_inst, imm_i_l_jalr, imm_s, imm_b, imm_jal, imm_u, imm_sel} !==
                   {e.pc, e.inst, e.i, e.s, e.b, e.j, e.u, e.sel})
                  $display("FAIL sb_entry got pc=%h inst=%h i=%h s=%h b=%h j=%h u=%h sel=%0d expected pc=%h inst=%h i=%h s=%h b=%h j=%h u=%h sel=%0d",
                           out_pc, out_inst, imm_i_l_jalr, imm_s, imm_b, imm_jal, imm_u, imm_sel,
                           e.pc, e.inst, e.i, e.s, e.b, e.j, e.u, e.sel);
               else
                  n_pass++;
            end
         end
         if (flush)
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back(model(in_pc, in_inst));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_two(input logic [31:0] a, input logic [31:0] b);
      out_ready = 1'b0;
      in_valid  = 1'b1; in_pc = 64'h1000; in_inst = a;
      step();
      in_pc = 64'h1004; in_inst = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0;
      #12;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL reset_handshake got valid/ready=%b%b expected 01", out_valid, in_ready);
      else n_pass++;
      n_checks++;
      if ({out_pc, out_inst, imm_i_l_jalr, imm_s, imm_b, imm_jal, imm_u, imm_sel} !== '0)
         $display("FAIL reset_data got pc=%h inst=%h sel=%0d expected all zero", out_pc, out_inst, imm_sel);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_decode();
      logic [31:0] insts [6] = '{32'hFFF00093, 32'h02109093, 32'h0020A423, 32'hFFDFF06F, 32'h123452B7, 32'h002081B3};
      logic [3:0]  sels  [6] = '{4'd1, 4'd6, 4'd2, 4'd4, 4'd5, 4'd0};
      int          kind  [6] = '{0, 0, 1, 4, 5, 9};
      logic [19:0] fval  [6] = '{20'hFFF, 20'h021, 20'h008, 20'hFFFFE, 20'h12345, 20'h0};
      logic [19:0] got;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_pc    = 64'h80000000 + 64'(4 * k);
         in_inst  = insts[k];
         step();
         in_valid = 1'b0;
         n_checks++;
         if ({out_valid, out_pc, imm_sel} !== {1'b1, 64'h80000000 + 64'(4 * k), sels[k]})
            $display("FAIL decode_%0d got valid=%b pc=%h sel=%0d expected valid=1 pc=%h sel=%0d",
                     k, out_valid, out_pc, imm_sel, 64'h80000000 + 64'(4 * k), sels[k]);
         else n_pass++;
         if (kind[k] != 9) begin
            case (kind[k])
               0:       got = {8'h0, imm_i_l_jalr};
               1:       got = {8'h0, imm_s};
               4:       got = imm_jal;
               default: got = imm_u;
            endcase
            n_checks++;
            if (got !== fval[k])
               $display("FAIL decode_field_%0d got %h expected %h", k, got, fval[k]);
            else n_pass++;
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      load_two(32'h00100113, 32'h00200193);
      n_checks++;
      if ({in_ready, out_valid, out_inst} !== {1'b0, 1'b1, 32'h00100113})
         $display("FAIL bp_full got ready=%b valid=%b inst=%h expected ready=0 valid=1 inst=00100113",
                  in_ready, out_valid, out_inst);
      else n_pass++;
      step();
      n_checks++;
      if ({out_valid, out_pc, out_inst, imm_sel} !== {1'b1, 64'h1000, 32'h00100113, 4'd1})
         $display("FAIL bp_hold got valid=%b pc=%h inst=%h sel=%0d expected A held", out_valid, out_pc, out_inst, imm_sel);
      else n_pass++;
      out_ready = 1'b1;
      step();
      n_checks++;
      if ({out_valid, in_ready, out_inst} !== {1'b1, 1'b1, 32'h00200193})
         $display("FAIL bp_second got valid=%b ready=%b inst=%h expected 1 1 00200193", out_valid, in_ready, out_inst);
      else n_pass++;
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL bp_drained got valid/ready=%b%b expected 01", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_flush();
      logic seen;
      load_two(32'h00300213, 32'h00400293);
      in_valid = 1'b1; in_pc = 64'h2000; in_inst = 32'h00500313; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, imm_sel} !== {1'b0, 1'b1, 4'd0})
         $display("FAIL flush_two got valid=%b ready=%b sel=%0d expected 0 1 0", out_valid, in_ready, imm_sel);
      else n_pass++;
      in_valid = 1'b1; in_pc = 64'h3000; in_inst = 32'h00600393;
      step();
      in_pc = 64'h3004; in_inst = 32'h0070A423; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, imm_sel} !== {1'b0, 1'b1, 4'd0})
         $display("FAIL flush_one got valid=%b ready=%b sel=%0d expected 0 1 0", out_valid, in_ready, imm_sel);
      else n_pass++;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         seen |= out_valid;
      end
      n_checks++;
      if (seen !== 1'b0)
         $display("FAIL flush_dropped got out_valid=1 after flush expected 0");
      else n_pass++;
   endtask

   task automatic test_async_reset();
      load_two(32'h00800413, 32'h00900493);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL async_reset got valid/ready=%b%b expected 01 before clock edge", out_valid, in_ready);
      else n_pass++;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 64'h4000; in_inst = 32'h00001537;
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_pc, out_inst, imm_u, imm_sel} !== {1'b1, 64'h4000, 32'h00001537, 20'h00001, 4'd5})
         $display("FAIL post_reset got valid=%b pc=%h inst=%h u=%h sel=%0d expected 1 4000 00001537 00001 5",
                  out_valid, out_pc, out_inst, imm_u, imm_sel);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [6:0] opcs [10] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
      logic       acc;
      int         waited;
      for (int n = 0; n < 40; n++) begin
         in_valid = 1'b1;
         in_pc    = {$urandom, $urandom};
         in_inst  = {$urandom} & 32'hFFFF_FF80 | {25'h0, opcs[$urandom_range(0, 9)]};
         acc = 1'b0;
         waited = 0;
         while (!acc) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            step();
            waited++;
            if (!acc && waited > 50) begin
               n_checks++;
               $display("FAIL b2b_timeout got in_ready stuck 0 expected accept within 50 cycles");
               break;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++)
         step();
      step();
      n_checks++;
      if ({out_valid, 32'(sb.size())} !== {1'b0, 32'd0})
         $display("FAIL b2b_drain got valid=%b pending=%0d expected 0 0", out_valid, sb.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- IF→ID pipeline register that sits directly upstream of the immediate decoder.
- Accepts fetched {pc, inst} over a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Presents registered raw immediate fields plus a 4-bit immediate-select code, already sliced from the instruction.
- The decoder sign/zero-extends these fields combinationally; decode and execute consume the rest downstream.

Parameters:
- XLEN, 64, width of pc path.
- ILEN, 32, instruction width; fixed, not intended to be overridden.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous kill of all buffered entries (redirect/branch mispredict).
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  XLEN  pc of in_inst.
- in_inst  in  ILEN  raw instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_pc  out  XLEN  pc of head.
- out_inst  out  ILEN  raw instruction of head.
- imm_i_l_jalr  out  12  inst[31:20].
- imm_s  out  12  {inst[31:25], inst[11:7]}.
- imm_b  out  12  {inst[31], inst[7], inst[30:25], inst[11:8]} (bit0 of offset implied zero).
- imm_jal  out  20  {inst[31], inst[19:12], inst[20], inst[30:21]} (bit0 implied zero).
- imm_u  out  20  inst[31:12].
- imm_sel  out  4  0 none, 1 I/load/jalr, 2 S, 3 B, 4 J, 5 U, 6 shamt.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, in_ready=1.
  - out_pc, out_inst, all imm fields and imm_sel = 0.
  - Both skid slots invalid.
- Storage and latency:
  - Field slicing and imm_sel are computed combinationally from in_inst.
  - The slice results are stored together with pc/inst, so every output is a flop output.
  - Latency in_valid&in_ready → out_valid is 1 cycle.
- imm_sel mapping by opcode inst[6:0]:
  - 0000011, 1100111 → 1.
  - 0010011, 0011011 → 1, except funct3 001/101 → 6.
  - 0100011 → 2.
  - 1100011 → 3.
  - 1101111 → 4.
  - 0110111, 0010111 → 5.
  - Everything else (OP, OP-32, FENCE, SYSTEM, illegal) → 0.
- States (slot count): EMPTY (0), ONE (main valid), TWO (main+skid valid).
  - in_ready = (state != TWO), registered.
  - EMPTY: accept → ONE (load main).
  - ONE:
    - accept & out_ready → ONE (main reloads).
    - accept & !out_ready → TWO (load skid).
    - !accept & out_ready → EMPTY.
    - else hold.
  - TWO: out_ready → ONE (skid→main); no accept possible.
- Outputs come from main. When main is valid and out_ready=0, every output stays stable.
- Transfer rules:
  - Transfer in only when in_valid&in_ready.
  - Transfer out only when out_valid&out_ready.
  - out_valid must not drop without a transfer-out, except on flush or reset.
- flush (synchronous, highest priority):
  - Next state is EMPTY and in_ready=1 next cycle.
  - An in_valid&in_ready on the same cycle is dropped.
  - Data registers need not clear; imm_sel is cleared to 0.
- Reset mid-operation: immediately returns to the reset values; buffered entries are lost.
- pc is carried unchanged; no arithmetic in this block.

Decomposition:
- Shared package (or a header of localparams) holds:
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - IMM_SEL_* codes 0–6, the single source for both this block and the immediate decoder.
- Natural sub-module: inst_field_slice, purely combinational: inst → five fields + imm_sel.
- The skid/state logic stays in id_stage_reg.

Test Plan:
- addi x1,x0,-1 (0xFFF00093) at pc 0x80000000, out_ready=1 → next cycle out_valid=1, imm_i_l_jalr=0xFFF, imm_sel=1, out_pc=0x80000000.
- slli x1,x1,33 (0x02109093) → imm_sel=6, imm_i_l_jalr=0x021. Then sw x2,8(x1) (0x0020A423) → imm_sel=2, imm_s=0x008.
- jal x0,-4 (0xFFDFF06F) → imm_sel=4, imm_jal=0xFFFFE. lui x5,0x12345 (0x123452B7) → imm_sel=5, imm_u=0x12345. add (0x002081B3) → imm_sel=0.
- Backpressure:
  - Setup: out_ready=0, send A then B back-to-back.
  - Cycle after B is accepted: in_ready=0 and out holds A stable.
  - Raise out_ready: A then B drain in order with no loss or duplication, then out_valid=0 and in_ready=1.
- Flush: state TWO, assert flush with in_valid=1 for C → next cycle out_valid=0, in_ready=1, imm_sel=0, and C is never emitted.
- Async reset pulse mid-stream in TWO → out_valid falls without waiting for a clock edge. After release, first accepted instruction appears 1 cycle later.
